// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Predicts combinationally at fetch, carries the prediction to EX, resolves and trains there.
module branch_predictor #(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_f,
  input  logic        stall_d,
  input  logic        flush_e,
  input  logic        branch_e,
  input  logic        taken_e,
  input  logic [31:0] pcplus4_e,
  input  logic [31:0] pcbranch_e,
  output logic        hit_f,
  output logic        predtaken_f,
  output logic [31:0] predtarget_f,
  output logic        mispredict_e,
  output logic [31:0] redirect_e
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX;

  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};

  function automatic logic [CTR_BITS-1:0] sat_inc(input logic [CTR_BITS-1:0] c);
    return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
  endfunction

  function automatic logic [CTR_BITS-1:0] sat_dec(input logic [CTR_BITS-1:0] c);
    return (c == '0) ? c : c - CTR_BITS'(1);
  endfunction

  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  logic        predtaken_p1_q, predtaken_p1_d;
  logic [31:0] predtarget_p1_q, predtarget_p1_d;
  logic        predtaken_p2_q, predtaken_p2_d;
  logic [31:0] predtarget_p2_q, predtarget_p2_d;

  // ---- Fetch: combinational lookup ----
  logic [IDX-1:0]   idx_f;
  logic [TAG_W-1:0] tag_f;

  assign idx_f = pc_f[IDX+1:2];
  assign tag_f = pc_f[31:IDX+2];

  always_comb begin
    hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    predtaken_f  = hit_f && ctr_q[idx_f][CTR_BITS-1];
    predtarget_f = hit_f ? target_q[idx_f] : pc_f + 32'd4;
  end

  // ---- IF/ID and ID/EX prediction carriers ----
  always_comb begin
    predtaken_p1_d  = predtaken_p1_q;
    predtarget_p1_d = predtarget_p1_q;
    if (mispredict_e) begin
      predtaken_p1_d  = 1'b0;
      predtarget_p1_d = '0;
    end else if (!stall_d) begin
      predtaken_p1_d  = predtaken_f;
      predtarget_p1_d = predtarget_f;
    end

    predtaken_p2_d  = predtaken_p1_q;
    predtarget_p2_d = predtarget_p1_q;
    if (mispredict_e || flush_e) begin
      predtaken_p2_d  = 1'b0;
      predtarget_p2_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      predtaken_p1_q  <= 1'b0;
      predtarget_p1_q <= '0;
      predtaken_p2_q  <= 1'b0;
      predtarget_p2_q <= '0;
    end else begin
      predtaken_p1_q  <= predtaken_p1_d;
      predtarget_p1_q <= predtarget_p1_d;
      predtaken_p2_q  <= predtaken_p2_d;
      predtarget_p2_q <= predtarget_p2_d;
    end
  end

  // ---- Execute: resolution ----
  logic [31:0]      pc_e;
  logic [IDX-1:0]   idx_e;
  logic [TAG_W-1:0] tag_e;
  logic             hit_e;

  assign pc_e  = pcplus4_e - 32'd4;
  assign idx_e = pc_e[IDX+1:2];
  assign tag_e = pc_e[31:IDX+2];
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  always_comb begin
    mispredict_e = 1'b0;
    redirect_e   = pcplus4_e;
    if (branch_e && taken_e && (!predtaken_p2_q || (predtarget_p2_q != pcbranch_e))) begin
      mispredict_e = 1'b1;
      redirect_e   = pcbranch_e;
    end else if (branch_e && !taken_e && predtaken_p2_q) begin
      mispredict_e = 1'b1;
    end else if (!branch_e && predtaken_p2_q) begin
      mispredict_e = 1'b1;
    end
  end

  // ---- Execute: table training ----
  logic                set_valid, clr_valid, ctr_en, tag_en, tgt_en;
  logic [CTR_BITS-1:0] ctr_d;

  always_comb begin
    set_valid = 1'b0;
    clr_valid = 1'b0;
    ctr_en    = 1'b0;
    tag_en    = 1'b0;
    tgt_en    = 1'b0;
    ctr_d     = ctr_q[idx_e];
    if (!reset) begin
      if (branch_e) begin
        if (hit_e) begin
          ctr_en = 1'b1;
          ctr_d  = taken_e ? sat_inc(ctr_q[idx_e]) : sat_dec(ctr_q[idx_e]);
          tgt_en = taken_e;
        end else if (taken_e) begin
          set_valid = 1'b1;
          tag_en    = 1'b1;
          tgt_en    = 1'b1;
          ctr_en    = 1'b1;
          ctr_d     = CTR_WT;
        end
      end else if (predtaken_p2_q && hit_e) begin
        // A non-branch that predicted taken owns a stale entry; drop it.
        clr_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else begin
      if (set_valid) valid_q[idx_e] <= 1'b1;
      if (clr_valid) valid_q[idx_e] <= 1'b0;
      if (ctr_en)    ctr_q[idx_e]   <= ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_en) tag_q[idx_e]    <= tag_e;
    if (tgt_en) target_q[idx_e] <= pcbranch_e;
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_f[1:0], pc_e[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table for the corner cases, then
// randomized traffic compared against an array-based reference model.
module tb_branch_predictor;

  localparam int ENT  = 16;
  localparam int CB   = 2;
  localparam int HALF = 1 << (CB - 1);
  localparam int CMAX = (1 << CB) - 1;

  logic        clk = 1'b0;
  logic        reset, stall_d, flush_e, branch_e, taken_e;
  logic [31:0] pc_f, pcplus4_e, pcbranch_e;
  logic        hit_f, predtaken_f, mispredict_e;
  logic [31:0] predtarget_f, redirect_e;

  int checks = 0;
  int failures = 0;

  branch_predictor #(.ENTRIES(ENT), .CTR_BITS(CB)) dut (
    .clk(clk), .reset(reset), .pc_f(pc_f), .stall_d(stall_d), .flush_e(flush_e),
    .branch_e(branch_e), .taken_e(taken_e), .pcplus4_e(pcplus4_e), .pcbranch_e(pcbranch_e),
    .hit_f(hit_f), .predtaken_f(predtaken_f), .predtarget_f(predtarget_f),
    .mispredict_e(mispredict_e), .redirect_e(redirect_e)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        stall, flush, br, tk;
    logic [31:0] p4, pb;
    logic        hit, pt;
    logic [31:0] tgt;
    logic        mis;
    logic [31:0] red;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [31:0] pc, input logic stall, input logic flush,
                     input logic br, input logic tk, input logic [31:0] p4, input logic [31:0] pb,
                     input logic hit, input logic pt, input logic [31:0] tgt, input logic mis,
                     input logic [31:0] red);
    vec_t v;
    v.rst = rst; v.pc = pc; v.stall = stall; v.flush = flush; v.br = br; v.tk = tk;
    v.p4 = p4; v.pb = pb; v.hit = hit; v.pt = pt; v.tgt = tgt; v.mis = mis; v.red = red;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [31:0] pc, input logic stall, input logic flush,
                       input logic br, input logic tk, input logic [31:0] p4, input logic [31:0] pb);
    reset = rst; pc_f = pc; stall_d = stall; flush_e = flush;
    branch_e = br; taken_e = tk; pcplus4_e = p4; pcbranch_e = pb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: table as plain arrays, counters as integers.
  bit          m_valid [ENT];
  logic [31:0] m_tag   [ENT];
  logic [31:0] m_tgt   [ENT];
  int          m_ctr   [ENT];
  bit          m_pt_id, m_pt_ex;
  logic [31:0] m_tg_id, m_tg_ex;
  bit          e_hit, e_pt, e_mis;
  logic [31:0] e_tgt, e_red;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % ENT);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / (4 * ENT);
  endfunction

  task automatic model_outputs();
    int i;
    i     = idx_of(pc_f);
    e_hit = m_valid[i] && (m_tag[i] == tag_of(pc_f));
    e_pt  = e_hit && (m_ctr[i] >= HALF);
    e_tgt = e_hit ? m_tgt[i] : pc_f + 32'd4;
    e_mis = 1'b0;
    e_red = pcplus4_e;
    if (branch_e && taken_e) begin
      if (!m_pt_ex || m_tg_ex != pcbranch_e) begin
        e_mis = 1'b1;
        e_red = pcbranch_e;
      end
    end else if (m_pt_ex) begin
      e_mis = 1'b1;
    end
  endtask

  task automatic model_edge();
    logic [31:0] pce;
    int j;
    bit h;
    if (reset) begin
      for (int k = 0; k < ENT; k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = HALF - 1;
      end
      m_pt_id = 1'b0; m_pt_ex = 1'b0;
      return;
    end
    pce = pcplus4_e - 32'd4;
    j   = idx_of(pce);
    h   = m_valid[j] && (m_tag[j] == tag_of(pce));
    if (branch_e) begin
      if (h) begin
        if (taken_e) begin
          m_ctr[j] = (m_ctr[j] < CMAX) ? m_ctr[j] + 1 : CMAX;
          m_tgt[j] = pcbranch_e;
        end else begin
          m_ctr[j] = (m_ctr[j] > 0) ? m_ctr[j] - 1 : 0;
        end
      end else if (taken_e) begin
        m_valid[j] = 1'b1;
        m_tag[j]   = tag_of(pce);
        m_tgt[j]   = pcbranch_e;
        m_ctr[j]   = HALF;
      end
    end else if (m_pt_ex && h) begin
      m_valid[j] = 1'b0;
    end
    if (e_mis || flush_e) begin
      m_pt_ex = 1'b0;
    end else begin
      m_pt_ex = m_pt_id;
      m_tg_ex = m_tg_id;
    end
    if (e_mis) begin
      m_pt_id = 1'b0;
    end else if (!stall_d) begin
      m_pt_id = e_pt;
      m_tg_id = e_tgt;
    end
  endtask

  initial begin
    // Directed sequence: each row is one cycle, checked before its edge.
    add(0, 32'h40,  0,0,0,0, 32'h1000, 32'h0,  0,0, 32'h44,  0, 32'h1000);
    add(0, 32'h100, 0,0,1,1, 32'h0C,   32'h20, 0,0, 32'h104, 1, 32'h20);
    add(0, 32'h08,  0,0,0,0, 32'h1000, 32'h0,  1,1, 32'h20,  0, 32'h1000);
    add(0, 32'h100, 0,1,0,0, 32'h1000, 32'h0,  0,0, 32'h104, 0, 32'h1000);
    add(0, 32'h100, 0,0,0,0, 32'h2000, 32'h0,  0,0, 32'h104, 0, 32'h2000);
    for (int k = 0; k < 3; k++)
      add(0, 32'h100, 0,0,1,1, 32'h0C, 32'h20, 0,0, 32'h104, 1, 32'h20);
    add(0, 32'h100, 0,0,1,0, 32'h0C,   32'h20, 0,0, 32'h104, 0, 32'h0C);
    add(0, 32'h08,  0,0,1,0, 32'h0C,   32'h20, 1,1, 32'h20,  0, 32'h0C);
    add(0, 32'h08,  0,0,0,0, 32'h3000, 32'h0,  1,0, 32'h20,  0, 32'h3000);
    add(0, 32'h48,  0,0,0,0, 32'h4C,   32'h0,  0,0, 32'h4C,  1, 32'h4C);
    add(0, 32'h08,  0,0,0,0, 32'h3000, 32'h0,  1,0, 32'h20,  0, 32'h3000);
    add(0, 32'h100, 0,0,1,1, 32'h0C,   32'h20, 0,0, 32'h104, 1, 32'h20);
    add(0, 32'h08,  0,0,0,0, 32'h3000, 32'h0,  1,1, 32'h20,  0, 32'h3000);
    add(0, 32'h100, 1,0,1,1, 32'h5004, 32'h6000, 0,0, 32'h104, 1, 32'h6000);
    add(0, 32'h100, 0,0,0,0, 32'h3000, 32'h0,  0,0, 32'h104, 0, 32'h3000);
    add(0, 32'h100, 0,0,0,0, 32'h3000, 32'h0,  0,0, 32'h104, 0, 32'h3000);
    add(0, 32'h08,  0,0,0,0, 32'h3000, 32'h0,  1,1, 32'h20,  0, 32'h3000);
    add(0, 32'h100, 0,0,0,0, 32'h3000, 32'h0,  0,0, 32'h104, 0, 32'h3000);
    add(0, 32'h100, 0,0,0,0, 32'h0C,   32'h0,  0,0, 32'h104, 1, 32'h0C);
    add(0, 32'h08,  0,0,0,0, 32'h3000, 32'h0,  0,0, 32'h0C,  0, 32'h3000);
    add(1, 32'h100, 0,0,1,1, 32'h0C,   32'h20, 0,0, 32'h104, 1, 32'h20);
    add(0, 32'h08,  0,0,0,0, 32'h3000, 32'h0,  0,0, 32'h0C,  0, 32'h3000);
    add(0, 32'h5000,0,0,0,0, 32'h3000, 32'h0,  0,0, 32'h5004, 0, 32'h3000);

    drive(1, 32'h40, 0,0,0,0, 32'h1000, 32'h0);
    tick();
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].pc, vecs[i].stall, vecs[i].flush,
            vecs[i].br, vecs[i].tk, vecs[i].p4, vecs[i].pb);
      #2;
      chk($sformatf("v%0d_hit", i),  32'(hit_f),        32'(vecs[i].hit));
      chk($sformatf("v%0d_pt", i),   32'(predtaken_f),  32'(vecs[i].pt));
      chk($sformatf("v%0d_tgt", i),  predtarget_f,      vecs[i].tgt);
      chk($sformatf("v%0d_mis", i),  32'(mispredict_e), 32'(vecs[i].mis));
      chk($sformatf("v%0d_red", i),  redirect_e,        vecs[i].red);
      tick();
    end

    // Randomized phase: start model and DUT from a common reset.
    drive(1, 32'h0, 0,0,0,0, 32'h4, 32'h0);
    model_edge();
    tick();
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 99) < 2),
            32'($urandom_range(0, 47)) << 2,
            ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 10),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            32'($urandom_range(1, 48)) << 2,
            32'($urandom_range(0, 7)) << 4);
      #2;
      model_outputs();
      chk($sformatf("r%0d_hit", n), 32'(hit_f),        32'(e_hit));
      chk($sformatf("r%0d_pt", n),  32'(predtaken_f),  32'(e_pt));
      chk($sformatf("r%0d_tgt", n), predtarget_f,      e_tgt);
      chk($sformatf("r%0d_mis", n), 32'(mispredict_e), 32'(e_mis));
      chk($sformatf("r%0d_red", n), redirect_e,        e_red);
      model_edge();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
